// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the forwarding unit.
package hazard_ctrl_pkg;

    // Sequencer states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1
    } hz_state_e;

    // Forwarding mux selects, shared with forwarding_unit.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is never a real dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, for performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count enabled cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle mul/div in EX and data-memory wait states in MEM.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic             bubble_mem_wb,
    output logic             md_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MD_TIMEOUT - 1);

    hz_state_e     state_q, state_d;
    logic          done_seen_q, done_seen_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          md_timeout_q, md_timeout_d;

    logic mem_hold;
    logic done_eff;
    logic md_hold;
    logic load_use;

    assign mem_hold = mem_req && !mem_ready;
    assign done_eff = muldiv_done || done_seen_q;
    assign md_hold  = (state_q == MD_WAIT) && !(done_eff && !mem_hold);
    assign load_use = load_use_hit(id_ex_mem_read, id_ex_rd, id_rs1, id_rs2,
                                   id_use_rs1, id_use_rs2);

    // State, pending-done flag, timeout counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            done_seen_q  <= 1'b0;
            to_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_seen_q  <= done_seen_d;
            to_cnt_q     <= to_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Next-state logic plus the prioritised stall/flush/bubble outputs.
    always_comb begin
        state_d       = state_q;
        done_seen_d   = done_seen_q;
        to_cnt_d      = to_cnt_q;
        md_timeout_d  = md_timeout_q;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        bubble_mem_wb = 1'b0;

        case (state_q)
            RUN: begin
                // The start cycle itself does not stall; a done seen here is ignored.
                if (ex_muldiv_start && !mem_hold) begin
                    state_d     = MD_WAIT;
                    to_cnt_d    = '0;
                    done_seen_d = 1'b0;
                end
            end
            MD_WAIT: begin
                if (done_eff && !mem_hold) begin
                    state_d     = RUN;
                    done_seen_d = 1'b0;
                    to_cnt_d    = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d      = RUN;
                    done_seen_d  = 1'b0;
                    to_cnt_d     = '0;
                    md_timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    // Result arrived while MEM froze EX/MEM: remember it.
                    if (muldiv_done && mem_hold) begin
                        done_seen_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!rst_n) begin
            flush_if_id   = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_ex_mem = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (mem_hold) begin
            stall_if      = 1'b1;
            stall_id      = 1'b1;
            stall_ex      = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (md_hold) begin
            stall_if      = 1'b1;
            stall_id      = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (ex_branch_taken) begin
            // Squashes the dependent instruction, so load-use is moot.
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (load_use) begin
            stall_if     = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .en    (stall_if),
        .count (stall_cycles)
    );

    assign state      = state_q;
    assign md_timeout = md_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational hazard table plus
// multi-cycle mul/div, memory-wait, timeout, reset and saturation sequences.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_use_rs1, id_use_rs2, id_ex_mem_read;
    logic       ex_branch_taken, ex_muldiv_start, muldiv_done;
    logic       mem_req, mem_ready;

    logic        stall_if, stall_id, stall_ex, flush_if_id;
    logic        bubble_id_ex, bubble_ex_mem, bubble_mem_wb, md_timeout;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    logic        s4_if, s4_id, s4_ex, f4, b4_idex, b4_exmem, b4_memwb, to4;
    logic [1:0]  state4;
    logic [3:0]  stall_cycles4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
        .muldiv_done(muldiv_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .bubble_ex_mem(bubble_ex_mem), .bubble_mem_wb(bubble_mem_wb),
        .md_timeout(md_timeout), .state(state), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
        .muldiv_done(muldiv_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(s4_if), .stall_id(s4_id), .stall_ex(s4_ex),
        .flush_if_id(f4), .bubble_id_ex(b4_idex),
        .bubble_ex_mem(b4_exmem), .bubble_mem_wb(b4_memwb),
        .md_timeout(to4), .state(state4), .stall_cycles(stall_cycles4)
    );

    // {stall_if, stall_id, stall_ex, flush_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb}
    logic [6:0] outs;
    assign outs = {stall_if, stall_id, stall_ex, flush_if_id,
                   bubble_id_ex, bubble_ex_mem, bubble_mem_wb};

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic       branch;
        logic       req;
        logic       ready;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_ex_rd = 5'd0; id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[1]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000100};
        vecs[2]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000100};
        vecs[3]  = '{5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[4]  = '{5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[5]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        vecs[6]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0001100};
        vecs[7]  = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0001100};
        vecs[8]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1110001};
        vecs[9]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 7'b1000100};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0000000};

        // Reset: outputs forced even with a memory hold pending.
        idle_inputs();
        rst_n = 1'b0;
        mem_req = 1'b1;
        #1;
        @(negedge clk);
        chk("reset_outs", 32'(outs), 32'(7'b0001111));
        cyc();
        cyc();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", stall_cycles, 32'd0);
        chk("reset_timeout", 32'(md_timeout), 32'd0);
        idle_inputs();
        rst_n = 1'b1;

        // Combinational hazard table in RUN.
        for (int i = 0; i < 11; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
            id_ex_rd = vecs[i].ex_rd; id_ex_mem_read = vecs[i].mem_read;
            ex_branch_taken = vecs[i].branch;
            mem_req = vecs[i].req; mem_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            cyc();
        end
        idle_inputs();
        chk("table_cnt", stall_cycles, 32'd4);

        // Mul/div of 5 cycles; done in the start cycle is ignored.
        do_reset();
        ex_muldiv_start = 1'b1;
        muldiv_done = 1'b1;
        @(negedge clk);
        chk("md_start_outs", 32'(outs), 32'd0);
        cyc();
        muldiv_done = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("md_wait%0d_state", i), 32'(state), 32'd1);
            chk($sformatf("md_wait%0d_outs", i), 32'(outs), 32'(7'b1100010));
            cyc();
        end
        muldiv_done = 1'b1;
        @(negedge clk);
        chk("md_done_state", 32'(state), 32'd1);
        chk("md_done_outs", 32'(outs), 32'd0);
        cyc();
        idle_inputs();
        chk("md_exit_state", 32'(state), 32'd0);
        chk("md_cnt", stall_cycles, 32'd4);

        // Memory wait during MD_WAIT with done arriving while frozen.
        do_reset();
        ex_muldiv_start = 1'b1;
        cyc();
        @(negedge clk);
        chk("mw_md_outs", 32'(outs), 32'(7'b1100010));
        cyc();
        for (int i = 0; i < 3; i++) begin
            mem_req = 1'b1; mem_ready = 1'b0;
            muldiv_done = (i == 1);
            @(negedge clk);
            chk($sformatf("mw_frozen%0d_outs", i), 32'(outs), 32'(7'b1110001));
            chk($sformatf("mw_frozen%0d_state", i), 32'(state), 32'd1);
            cyc();
        end
        muldiv_done = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_release_outs", 32'(outs), 32'd0);
        cyc();
        idle_inputs();
        chk("mw_exit_state", 32'(state), 32'd0);
        chk("mw_cnt", stall_cycles, 32'd4);

        // Timeout after 8 MD_WAIT cycles with no done.
        do_reset();
        ex_muldiv_start = 1'b1;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d_state", i), 32'(state), 32'd1);
            chk($sformatf("to_wait%0d_flag", i), 32'(md_timeout), 32'd0);
            cyc();
        end
        ex_muldiv_start = 1'b0;
        chk("to_exit_state", 32'(state), 32'd0);
        chk("to_flag_set", 32'(md_timeout), 32'd1);
        cyc();
        cyc();
        chk("to_flag_sticky", 32'(md_timeout), 32'd1);
        chk("to_cnt", stall_cycles, 32'd8);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("to_flag_cleared", 32'(md_timeout), 32'd0);

        // Reset in MD_WAIT drops a pending done.
        do_reset();
        ex_muldiv_start = 1'b1;
        cyc();
        mem_req = 1'b1; mem_ready = 1'b0; muldiv_done = 1'b1;
        cyc();
        do_reset();
        chk("rmd_state", 32'(state), 32'd0);
        ex_muldiv_start = 1'b1;
        cyc();
        @(negedge clk);
        chk("rmd_no_stale_done", 32'(outs), 32'(7'b1100010));
        cyc();

        // Continuous memory hold saturates the narrow counter.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        idle_inputs();
        chk("sat_cnt4", 32'(stall_cycles4), 32'd15);
        chk("sat_cnt32", stall_cycles, 32'd20);
        cyc();
        chk("sat_cnt4_hold", 32'(stall_cycles4), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
